addr_mode_seq: RTL
==================

ADDR_MODE_SEQ -- requirements
Module: addr_mode_seq

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn_i  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port start_i  input  1  begin sequencing; sampled only in IDLE.
REQ-004 SHALL have port mode_i  input  3  addressing mode: 0 IMM, 1 ZP, 2 ZPX, 3 ZPY, 4 ABS, 5 ABSX, 6 ABSY, 7 reserved.
REQ-005 SHALL have ports pc_i  input  16 (operand address), x_i  input  8, y_i  input  8; all latched on accepted start.
REQ-006 SHALL have ports mem_req_o  output  1, mem_addr_o  output  16, mem_gnt_i  input  1, mem_rdata_i  input  8 (valid in the mem_gnt_i cycle).
REQ-007 SHALL have ports alu_op_o  output  alu_op_t, alu_a_o  output  16, alu_b_o  output  16, alu_res_i  input  16 (combinational ALU result, same cycle).
REQ-008 SHALL have ports busy_o  output  1, done_o  output  1, ea_o  output  16, bytes_o  output  2 (operand bytes consumed), page_cross_o  output  1.

Function
REQ-009 SHALL implement states IDLE, FETCH_LO, FETCH_HI, INDEX, FIX, DONE; busy_o=1 in every state except IDLE.
REQ-010 IDLE: on start_i=1 SHALL latch mode/pc/x/y; IMM or reserved -> DONE, otherwise -> FETCH_LO; start_i outside IDLE SHALL be ignored.
REQ-011 FETCH_LO: mem_req_o=1, mem_addr_o=latched pc; held stable until mem_gnt_i=1; on grant latch lo=mem_rdata_i.
REQ-012 FETCH_LO exit on grant: ZP -> DONE; ZPX/ZPY -> INDEX; ABS/ABSX/ABSY -> FETCH_HI.
REQ-013 FETCH_HI: mem_req_o=1, mem_addr_o=pc+1 (16-bit wrap, FFFF -> 0000); on grant latch hi; ABS -> DONE, ABSX/ABSY -> INDEX.
REQ-014 INDEX zero-page: alu_op_o=ALU_ADD_ZEROPAGE, alu_a_o={00,lo}, alu_b_o={00,X or Y}; ea={00,alu_res_i[7:0]} (wrap within page 00); -> DONE.
REQ-015 INDEX absolute: alu_op_o=ALU_ADD, alu_a_o={hi,lo}, alu_b_o={00,X or Y}; ea=alu_res_i (16-bit wrap); page cross = alu_res_i[15:8] != hi.
REQ-016 Outside INDEX SHALL drive alu_op_o=ALU_BYPASS_A, alu_a_o=0, alu_b_o=0; mem_req_o=0 outside FETCH_LO/FETCH_HI, mem_addr_o=0 when mem_req_o=0.
REQ-017 DONE: done_o=1 for exactly one cycle, then -> IDLE; ea_o, bytes_o, page_cross_o valid from DONE and held until next accepted start.
REQ-018 ea results: IMM ea=pc, bytes=1... except IMM bytes_o=0 (no fetch); ZP ea={00,lo}, bytes=1; ZPX/ZPY bytes=1; ABS ea={hi,lo}, bytes=2; ABSX/ABSY bytes=2.
REQ-019 Latency with grant in first request cycle, start at cycle T: IMM done T+1; ZP T+2; ZPX T+3; ABS T+3; ABSX no cross T+4.
REQ-020 Each grant-wait cycle SHALL add exactly one cycle of latency; mem_gnt_i outside request states SHALL be ignored.

Reset
REQ-021 rstn_i=0 at a rising edge SHALL force IDLE from any state, including mid-fetch, discarding latched operands.
REQ-022 After reset all outputs SHALL be 0 (alu_op_o=ALU_BYPASS_A); start_i in the first cycle after release SHALL be accepted.

Configuration
REQ-023 Macro PAGE_CROSS_PENALTY_EN defined: ABSX/ABSY with page cross SHALL pass INDEX -> FIX (one idle cycle, busy_o=1) -> DONE, page_cross_o=1.
REQ-024 Macro undefined: INDEX -> DONE always, FIX unreachable, page_cross_o constant 0.

Verification
REQ-025 ZP: mode=1, pc=0300, grant immediate, rdata=44 -> mem_addr_o=0300, done at T+2, ea_o=0044, bytes_o=1.
REQ-026 ZPX wrap: mode=2, rdata=F0, x=20 -> INDEX alu_op_o=ALU_ADD_ZEROPAGE, ea_o=0010, done T+3.
REQ-027 ABSX cross: mode=5, pc=0400, lo=FF, hi=12, x=01 -> ea_o=1300; with PAGE_CROSS_PENALTY_EN done T+5, page_cross_o=1; without done T+4, page_cross_o=0.
REQ-028 Wait states: ABS, mem_gnt_i low 3 cycles in FETCH_LO -> mem_addr_o stable 0400, then 0401, done T+6, start_i pulses while busy ignored.
REQ-029 Reset mid-op: rstn_i=0 during FETCH_HI -> next cycle IDLE, mem_req_o=0, done_o never pulses; fresh IMM start pc=8000 -> ea_o=8000 at T+1.
REQ-030 PC wrap: ABS pc=FFFF -> second request mem_addr_o=0000.

Source files
------------

// File: rtl/addr_mode_seq.sv
// addr_mode_seq: operand address sequencer for an 8-bit style CPU.
// Walks an addressing mode through operand fetches (lo/hi byte), an optional
// index add through an external combinational ALU and reports the effective
// address, operand byte count and page-cross flag.
// Optional feature macro: PAGE_CROSS_PENALTY_EN -- when defined, indexed
// absolute modes that cross a page spend one extra FIX cycle and raise
// page_cross_o; when undefined FIX is unreachable and page_cross_o is 0.
//
// Handshake: mem_req_o/mem_addr_o are held stable while in a fetch state until
// a cycle with mem_gnt_i=1; that cycle completes the transfer and mem_rdata_i
// is captured on its closing edge. mem_gnt_i is ignored whenever mem_req_o=0.

package addr_mode_seq_pkg;
    typedef enum logic [1:0] {
        ALU_BYPASS_A     = 2'd0,
        ALU_ADD          = 2'd1,
        ALU_ADD_ZEROPAGE = 2'd2
    } alu_op_t;
endpackage

module addr_mode_seq
    import addr_mode_seq_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic [2:0]  mode_i,
    input  logic [15:0] pc_i,
    input  logic [7:0]  x_i,
    input  logic [7:0]  y_i,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic [7:0]  mem_rdata_i,
    output alu_op_t     alu_op_o,
    output logic [15:0] alu_a_o,
    output logic [15:0] alu_b_o,
    input  logic [15:0] alu_res_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] ea_o,
    output logic [1:0]  bytes_o,
    output logic        page_cross_o,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_LO = 3'd1,
        FETCH_HI = 3'd2,
        INDEX    = 3'd3,
        FIX      = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [2:0] M_IMM  = 3'd0;
    localparam logic [2:0] M_ZP   = 3'd1;
    localparam logic [2:0] M_ZPX  = 3'd2;
    localparam logic [2:0] M_ZPY  = 3'd3;
    localparam logic [2:0] M_ABS  = 3'd4;
    localparam logic [2:0] M_ABSX = 3'd5;
    localparam logic [2:0] M_RSV  = 3'd7;

    state_t      state, state_nx;
    logic [2:0]  mode_r;
    logic [15:0] pc_r;
    logic [7:0]  x_r, y_r, lo_r, hi_r;
    logic [15:0] ea_r;
    logic [1:0]  bytes_r;
    logic        pcross_r;

    logic        zp_indexed;
    logic [7:0]  idx;
    logic        take_fix;

    assign zp_indexed = (mode_r == M_ZPX) || (mode_r == M_ZPY);
    assign idx        = ((mode_r == M_ZPX) || (mode_r == M_ABSX)) ? x_r : y_r;

    // Page cross only matters for indexed absolute modes in INDEX.
`ifdef PAGE_CROSS_PENALTY_EN
    logic cross;
    assign cross    = (alu_res_i[15:8] != hi_r);
    assign take_fix = !zp_indexed && cross;
`else
    assign take_fix = 1'b0;
`endif

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_nx   = state;
        mem_req_o  = 1'b0;
        mem_addr_o = 16'h0000;
        alu_op_o   = ALU_BYPASS_A;
        alu_a_o    = 16'h0000;
        alu_b_o    = 16'h0000;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (mode_i == M_IMM || mode_i == M_RSV) state_nx = DONE;
                    else                                    state_nx = FETCH_LO;
                end
            end
            FETCH_LO: begin
                mem_req_o  = 1'b1;
                mem_addr_o = pc_r;
                if (mem_gnt_i) begin
                    if (mode_r == M_ZP)  state_nx = DONE;
                    else if (zp_indexed) state_nx = INDEX;
                    else                 state_nx = FETCH_HI;
                end
            end
            FETCH_HI: begin
                mem_req_o  = 1'b1;
                mem_addr_o = pc_r + 16'd1;
                if (mem_gnt_i) begin
                    if (mode_r == M_ABS) state_nx = DONE;
                    else                 state_nx = INDEX;
                end
            end
            INDEX: begin
                alu_op_o = zp_indexed ? ALU_ADD_ZEROPAGE : ALU_ADD;
                alu_a_o  = zp_indexed ? {8'h00, lo_r} : {hi_r, lo_r};
                alu_b_o  = {8'h00, idx};
                state_nx = take_fix ? FIX : DONE;
            end
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latches and result registers, updated as each stage completes.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            mode_r   <= 3'd0;
            pc_r     <= 16'h0000;
            x_r      <= 8'h00;
            y_r      <= 8'h00;
            lo_r     <= 8'h00;
            hi_r     <= 8'h00;
            ea_r     <= 16'h0000;
            bytes_r  <= 2'd0;
            pcross_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        mode_r   <= mode_i;
                        pc_r     <= pc_i;
                        x_r      <= x_i;
                        y_r      <= y_i;
                        lo_r     <= 8'h00;
                        hi_r     <= 8'h00;
                        bytes_r  <= 2'd0;
                        pcross_r <= 1'b0;
                        ea_r     <= (mode_i == M_IMM) ? pc_i : 16'h0000;
                    end
                end
                FETCH_LO: begin
                    if (mem_gnt_i) begin
                        lo_r    <= mem_rdata_i;
                        bytes_r <= 2'd1;
                        if (mode_r == M_ZP) ea_r <= {8'h00, mem_rdata_i};
                    end
                end
                FETCH_HI: begin
                    if (mem_gnt_i) begin
                        hi_r    <= mem_rdata_i;
                        bytes_r <= 2'd2;
                        ea_r    <= {mem_rdata_i, lo_r};
                    end
                end
                INDEX: begin
                    ea_r     <= zp_indexed ? {8'h00, alu_res_i[7:0]} : alu_res_i;
                    pcross_r <= take_fix;
                end
                default: ;
            endcase
        end
    end

    assign busy_o       = (state != IDLE);
    assign done_o       = (state == DONE);
    assign ea_o         = ea_r;
    assign bytes_o      = bytes_r;
    assign page_cross_o = pcross_r;
    assign dbg_state_o  = state;

endmodule
